// File: rtl/universal_shift_reg_burst.sv
// Universal shift register with burst engine.
// A command accepted in IDLE either acts immediately (hold, load, clear) or
// starts a burst of single-bit shift/rotate steps executed one per cycle in RUN.
// The done flag pulses for one cycle when a command completes. cmd_ready is
// high during that cycle, so commands can be issued back-to-back.
module universal_shift_reg_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_mode,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] data_in,
   input  logic             msb_in,
   input  logic             lsb_in,
   output logic [WIDTH-1:0] data_out,
   output logic             msb_out,
   output logic             lsb_out,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_SHR   = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_ROR   = 3'b100;
   localparam logic [2:0] M_ROL   = 3'b101;
   localparam logic [2:0] M_ASR   = 3'b110;
   localparam logic [2:0] M_CLEAR = 3'b111;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]       state;
   logic [CNT_W-1:0] remaining;
   logic [2:0]       mode_q;
   logic [WIDTH-1:0] data_q;
   logic             done_q;

   // One single-bit step of a step mode; non-step modes leave the value alone.
   function automatic logic [WIDTH-1:0] step_val(
      input logic [2:0]       mode,
      input logic [WIDTH-1:0] d,
      input logic             s_msb,
      input logic             s_lsb
   );
      logic [WIDTH-1:0] r;
      r = d;
      case (mode)
         M_SHR:   r = {s_msb, d[WIDTH-1:1]};
         M_SHL:   r = {d[WIDTH-2:0], s_lsb};
         M_ROR:   r = {d[0], d[WIDTH-1:1]};
         M_ROL:   r = {d[WIDTH-2:0], d[WIDTH-1]};
         M_ASR:   r = {d[WIDTH-1], d[WIDTH-1:1]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Command acceptance, burst stepping and completion pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         remaining <= '0;
         mode_q    <= M_HOLD;
         data_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_mode)
                     M_HOLD: begin
                        done_q <= 1'b1;
                     end
                     M_LOAD: begin
                        data_q <= data_in;
                        done_q <= 1'b1;
                     end
                     M_CLEAR: begin
                        data_q <= '0;
                        done_q <= 1'b1;
                     end
                     default: begin
                        // A zero-length burst completes without touching the data.
                        if (cmd_count == '0) begin
                           done_q <= 1'b1;
                        end else begin
                           mode_q    <= cmd_mode;
                           remaining <= cmd_count;
                           state     <= S_RUN;
                        end
                     end
                  endcase
               end
            end
            default: begin
               data_q    <= step_val(mode_q, data_q, msb_in, lsb_in);
               remaining <= remaining - CNT_ONE;
               if (remaining == CNT_ONE) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state == S_RUN);
   assign done      = done_q;
   assign data_out  = data_q;
   assign msb_out   = data_q[WIDTH-1];
   assign lsb_out   = data_q[0];

endmodule

// File: tb/tb_universal_shift_reg_burst.sv
// Bench for universal_shift_reg_burst (WIDTH=8, CNT_W=4).
// A transaction-level model tracks the expected register value, the number of
// burst steps left and the done pulse. It is checked against the DUT every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_universal_shift_reg_burst;

   localparam int W = 8;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_mode = 3'b000;
   logic [C-1:0] cmd_count = '0;
   logic [W-1:0] data_in = '0;
   logic         msb_in = 1'b0;
   logic         lsb_in = 1'b0;
   logic [W-1:0] data_out;
   logic         msb_out;
   logic         lsb_out;
   logic         busy;
   logic         done;

   int vectors = 0;
   int miscompares = 0;

   universal_shift_reg_burst #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_count(cmd_count), .data_in(data_in),
      .msb_in(msb_in), .lsb_in(lsb_in), .data_out(data_out),
      .msb_out(msb_out), .lsb_out(lsb_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: plain arithmetic on an 8-bit value.
   function automatic logic [W-1:0] model_step(input logic [2:0] m, input logic [W-1:0] d,
                                               input logic mi, input logic li);
      case (m)
         3'd1:    return (d >> 1) | (W'(mi) << (W-1));
         3'd2:    return (d << 1) | W'(li);
         3'd4:    return (d >> 1) | (d << (W-1));
         3'd5:    return (d << 1) | (d >> (W-1));
         3'd6:    return W'($signed(d) >>> 1);
         default: return d;
      endcase
   endfunction

   logic [W-1:0] m_d = '0;
   logic [2:0]   m_mode = '0;
   int           m_left = 0;
   bit           m_done = 0;
   bit           started = 0;

   always @(posedge clk) begin
      if (!rst) begin
         m_d = '0; m_mode = '0; m_left = 0; m_done = 0; started = 1;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            m_d = model_step(m_mode, m_d, msb_in, lsb_in);
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1;
         end else if (cmd_valid) begin
            if (cmd_mode == 3'd0) m_done = 1;
            else if (cmd_mode == 3'd3) begin m_d = data_in; m_done = 1; end
            else if (cmd_mode == 3'd7) begin m_d = '0; m_done = 1; end
            else if (cmd_count == 0) m_done = 1;
            else begin m_mode = cmd_mode; m_left = int'(cmd_count); end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("mdl_data", 32'(data_out), 32'(m_d));
         chk("mdl_msb", 32'(msb_out), 32'(m_d[W-1]));
         chk("mdl_lsb", 32'(lsb_out), 32'(m_d[0]));
         chk("mdl_busy", 32'(busy), 32'(m_left > 0));
         chk("mdl_ready", 32'(cmd_ready), 32'(m_left == 0));
         chk("mdl_done", 32'(done), 32'(m_done));
      end
   end

   // Present a command for one cycle; called and returns at a falling edge.
   task automatic issue(input logic [2:0] m, input int n, input logic [W-1:0] d);
      cmd_valid = 1'b1; cmd_mode = m; cmd_count = C'(n); data_in = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Wait (bounded) for done, counting busy cycles seen on the way.
   task automatic wait_done(input string nm, output int busy_cycles);
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) return;
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
      end
      chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int bc;
      repeat (2) @(negedge clk);
      chk("rst_data", 32'(data_out), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // 1: load
      issue(3'b011, 0, 8'hA5);
      chk("t1_data", 32'(data_out), 32'hA5);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_msb", 32'(msb_out), 32'd1);
      chk("t1_lsb", 32'(lsb_out), 32'd1);
      @(negedge clk);
      chk("t1_done_low", 32'(done), 32'd0);

      // 2: shift right 3 with msb_in=1
      msb_in = 1'b1;
      issue(3'b001, 3, 8'h00);
      chk("t2_b0", 32'(busy), 32'd1);
      chk("t2_d0", 32'(data_out), 32'hA5);
      @(negedge clk); chk("t2_d1", 32'(data_out), 32'hD2);
      @(negedge clk); chk("t2_d2", 32'(data_out), 32'hE9);
      chk("t2_b2", 32'(busy), 32'd1);
      @(negedge clk); chk("t2_d3", 32'(data_out), 32'hF4);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_b3", 32'(busy), 32'd0);
      msb_in = 1'b0;
      @(negedge clk);

      // 3: rotate left 1 and 8
      issue(3'b011, 0, 8'h81); @(negedge clk);
      issue(3'b101, 1, 8'h00);
      wait_done("t3a", bc);
      chk("t3a_data", 32'(data_out), 32'h03);
      chk("t3a_busy", 32'(bc), 32'd1);
      @(negedge clk);
      issue(3'b011, 0, 8'h81); @(negedge clk);
      issue(3'b101, 8, 8'h00);
      wait_done("t3b", bc);
      chk("t3b_data", 32'(data_out), 32'h81);
      chk("t3b_busy", 32'(bc), 32'd8);
      @(negedge clk);

      // 4: arithmetic right and shift left
      issue(3'b011, 0, 8'h80); @(negedge clk);
      issue(3'b110, 2, 8'h00);
      wait_done("t4a", bc);
      chk("t4a_data", 32'(data_out), 32'hE0);
      @(negedge clk);
      issue(3'b011, 0, 8'h0F); @(negedge clk);
      lsb_in = 1'b0;
      issue(3'b010, 4, 8'h00);
      wait_done("t4b", bc);
      chk("t4b_data", 32'(data_out), 32'hF0);
      chk("t4b_busy", 32'(bc), 32'd4);
      @(negedge clk);

      // 5: ignored command while busy, then reset aborts the burst
      issue(3'b011, 0, 8'hFF); @(negedge clk);
      msb_in = 1'b0;
      issue(3'b001, 5, 8'h00);
      issue(3'b011, 0, 8'h00);
      chk("t5_d1", 32'(data_out), 32'h7F);
      chk("t5_b1", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t5_d2", 32'(data_out), 32'h3F);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rst_data", 32'(data_out), 32'h00);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_ready", 32'(cmd_ready), 32'd1);
      chk("t5_rst_done", 32'(done), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_no_done", 32'(done), 32'd0);

      // 6: zero-count shift, then clear back-to-back in the done cycle
      issue(3'b011, 0, 8'h3C); @(negedge clk);
      issue(3'b010, 0, 8'h00);
      chk("t6_data", 32'(data_out), 32'h3C);
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_ready", 32'(cmd_ready), 32'd1);
      issue(3'b111, 0, 8'h00);
      chk("t6_clr", 32'(data_out), 32'h00);
      chk("t6_done2", 32'(done), 32'd1);
      @(negedge clk);
      chk("t6_done_low", 32'(done), 32'd0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/universal_shift_reg_burst.md
Name: universal_shift_reg_burst

Overview:
Parametrised successor to the 4-bit universal shift register. Adds configurable width, rotate / arithmetic-shift / clear modes, and a multi-step burst engine driven by a valid/ready command interface, with busy/done status. Sits between a control FSM or bus register and datapath logic that needs serialisation, bit alignment or rotation.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of the burst count field; max burst = 2^CNT_W - 1 steps

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command; high only in IDLE
cmd_mode  input  3  operation code, sampled on accept
cmd_count  input  CNT_W  number of single-bit steps for shift/rotate modes, sampled on accept
data_in  input  WIDTH  parallel load value, sampled on accept
msb_in  input  1  serial input for shift-right, sampled live on each step
lsb_in  input  1  serial input for shift-left, sampled live on each step
data_out  output  WIDTH  register contents
msb_out  output  1  data_out[WIDTH-1] (combinational)
lsb_out  output  1  data_out[0] (combinational)
busy  output  1  high while in RUN
done  output  1  registered one-cycle pulse at command completion

Behaviour:
- Reset (rst==0 at a rising edge): data_out=0, state=IDLE, remaining=0, latched mode=0, done=0. Overrides everything; reset in RUN aborts the burst with no done pulse.
- States: IDLE (cmd_ready=1, busy=0) and RUN (cmd_ready=0, busy=1).
- Accept = cmd_valid & cmd_ready. cmd_valid while busy is ignored, and the command is not queued.
- Modes: 000 hold; 001 shift right {msb_in, d[W-1:1]}; 010 shift left {d[W-2:0], lsb_in}; 011 parallel load data_in; 100 rotate right {d[0], d[W-1:1]}; 101 rotate left {d[W-2:0], d[W-1]}; 110 arithmetic shift right {d[W-1], d[W-1:1]}; 111 clear to 0.
- Immediate modes (000, 011, 111): data_out updated at the accept edge, done=1 in the following cycle, state stays IDLE.
- Step modes (001, 010, 100, 101, 110) with cmd_count==0: no-op. Data unchanged, done=1 in the following cycle, stays IDLE.
- Step modes with cmd_count=N>=1: at the accept edge, latch mode, set remaining=N, go to RUN. data_out is not changed on that edge.
  - Each RUN cycle performs exactly one step and decrements remaining.
  - On the edge performing the step with remaining==1: go to IDLE and set done=1.
  - busy is high for exactly N cycles. The final data is visible together with the done pulse, N+1 cycles after the accept cycle.
- done is high for one cycle only. cmd_ready is high in that same cycle, so a new command may be accepted back-to-back in the done cycle.
- Data inputs other than msb_in/lsb_in are don't-care outside the accept cycle.
- Rotate by N>=WIDTH wraps naturally: N=WIDTH returns the original value.

Test Plan (WIDTH=8, CNT_W=4):
1. Release reset, then load 0xA5 -> data_out=0xA5 one edge after accept, done pulse next cycle, busy never high, msb_out=1, lsb_out=1.
2. From 0xA5: shift right, count=3, msb_in=1 -> data_out sequence 0xD2, 0xE9, 0xF4; busy high for 3 cycles; done coincides with 0xF4.
3. From 0x81: rotate left, count=1 -> 0x03. Then rotate left, count=8 from 0x81 -> 0x81 after 8 steps.
4. From 0x80: arithmetic right, count=2 -> 0xE0. From 0x0F: shift left, count=4, lsb_in=0 -> 0xF0.
5. From 0xFF: start shift right, count=5, msb_in=0. Pulse cmd_valid with load 0x00 during busy -> ignored. Assert rst after 2 steps -> data_out=0x00, busy=0, no done pulse, cmd_ready=1.
6. From 0x3C: shift left, count=0 -> data unchanged, done next cycle. Present clear during the done cycle -> accepted, data_out=0x00, second done pulse one cycle later.
